// File: rtl/out_byte_uart_tx_if.sv
// Byte-strobe input and UART/status output bundle for out_byte_uart_tx.
// master = firmware-side producer/observer, slave = the UART transmitter.
interface out_byte_uart_tx_if #(
    parameter int unsigned FIFO_AW = 4
);
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             uart_tx;
    logic             tx_busy;
    logic [FIFO_AW:0] fifo_level;
    logic             overflow;

    modport master (
        output in_byte, in_valid,
        input  uart_tx, tx_busy, fifo_level, overflow
    );

    modport slave (
        input  in_byte, in_valid,
        output uart_tx, tx_busy, fifo_level, overflow
    );
endinterface

// File: rtl/out_byte_uart_tx.sv
// Buffers single-cycle byte strobes in a FIFO and serialises them as 8N1 UART frames.
// Overflowing bytes are dropped and flagged with a sticky overflow bit.
module out_byte_uart_tx #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic                clk,
    input  logic                reset,
    out_byte_uart_tx_if.slave   bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [FIFO_AW:0] FULL_LVL   = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] PTR_ONE    = (FIFO_AW+1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] level;
    logic             tx_q;
    logic             busy_q;
    logic             ovf_q;

    logic full_c;
    logic empty_c;
    logic bit_end_c;
    logic pop_c;
    logic push_c;

    // A pop frees a slot in the same cycle, so a push at full is still accepted then.
    always_comb begin
        full_c    = (level == FULL_LVL);
        empty_c   = (level == '0);
        bit_end_c = (baud_cnt == '0);
        pop_c     = !empty_c && ((state == IDLE) || ((state == STOP) && bit_end_c));
        push_c    = bus.in_valid && (!full_c || pop_c);
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= bus.in_byte;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_c, pop_c})
                2'b10:   level <= level + PTR_ONE;
                2'b01:   level <= level - PTR_ONE;
                default: level <= level;
            endcase
            if (bus.in_valid && !push_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Frame sequencer; the pin flop follows the state by one cycle so every bit keeps CLK_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            tx_q   <= (state == START) ? 1'b0 : ((state == DATA) ? shift[0] : 1'b1);
            busy_q <= (state != IDLE) || !empty_c;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        shift    <= mem[rd_ptr[FIFO_AW-1:0]];
                        baud_cnt <= BIT_RELOAD;
                        bit_idx  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        baud_cnt <= BIT_RELOAD;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        baud_cnt <= BIT_RELOAD;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        if (pop_c) begin
                            shift    <= mem[rd_ptr[FIFO_AW-1:0]];
                            baud_cnt <= BIT_RELOAD;
                            bit_idx  <= '0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.uart_tx    = tx_q;
    assign bus.tx_busy    = busy_q;
    assign bus.fifo_level = level;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_out_byte_uart_tx.sv
// Self-checking bench for out_byte_uart_tx: table-driven single frames, hand-written
// corner sequences, and randomized bursts checked by a line-decoding reference receiver.
module tb_out_byte_uart_tx;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned FIFO_AW = 2;
    localparam int unsigned FRAME   = 10 * CLK_DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    out_byte_uart_tx_if #(.FIFO_AW(FIFO_AW)) bus ();

    out_byte_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[9] goes out first: start, d0..d7, stop
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] rx_q[$];
    int         st_q[$];
    logic [7:0] exp_q[$];
    vec_t       vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal 8N1 waveform of one byte, one sample per clock, first sample in the MSB.
    function automatic logic [FRAME-1:0] expand(input logic [7:0] b);
        logic [FRAME-1:0] r;
        int j;
        for (int k = 0; k < int'(FRAME); k++) begin
            j = k / int'(CLK_DIV);
            r[int'(FRAME)-1-k] = (j == 0) ? 1'b0 : ((j == 9) ? 1'b1 : b[j-1]);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        tick();
        tick();
        while (bus.tx_busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        check("idle_timeout", 64'(n >= max), 64'(0));
    endtask

    task automatic check_rx(input string name);
        check({name, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check(name, 64'(rx_q[i]), 64'(exp_q[i]));
        end
    endtask

    // Reference receiver: captures every frame and checks it against the ideal waveform.
    initial begin
        logic [FRAME-1:0] cap;
        logic [7:0]       b;
        bit               abort;
        int               st;
        forever begin
            @(negedge clk);
            if (!reset && bus.uart_tx === 1'b0) begin
                st    = cyc;
                cap   = '0;
                abort = 1'b0;
                for (int k = 1; k < int'(FRAME); k++) begin
                    @(negedge clk);
                    if (reset) abort = 1'b1;
                    cap[int'(FRAME)-1-k] = bus.uart_tx;
                end
                if (!abort) begin
                    for (int i = 0; i < 8; i++)
                        b[i] = cap[int'(FRAME)-1-(int'(CLK_DIV)*(i+1) + int'(CLK_DIV)/2)];
                    check("frame_shape", 64'(cap), 64'(expand(b)));
                    rx_q.push_back(b);
                    st_q.push_back(st);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [FRAME-1:0] cap;
        logic [FRAME-1:0] want;
        logic [9:0]       ln;
        logic [7:0]       b;
        int               len;

        vecs[0] = '{8'h55, 10'b0101010101};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h01, 10'b0100000001};
        vecs[4] = '{8'h80, 10'b0000000011};
        vecs[5] = '{8'h3C, 10'b0001111001};

        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("rst_uart_tx", 64'(bus.uart_tx), 64'(1));
        check("rst_tx_busy", 64'(bus.tx_busy), 64'(0));
        check("rst_level",   64'(bus.fifo_level), 64'(0));
        check("rst_overflow", 64'(bus.overflow), 64'(0));

        // Single frames: exact latency, bit timing and idle afterwards.
        rx_q.delete();
        foreach (vecs[v]) begin
            strobe(vecs[v].data);
            check("lvl_after_push", 64'(bus.fifo_level), 64'(1));
            tick();
            check("lvl_after_pop", 64'(bus.fifo_level), 64'(0));
            check("tx_high_before_start", 64'(bus.uart_tx), 64'(1));
            check("busy_during_frame", 64'(bus.tx_busy), 64'(1));
            tick();
            ln = vecs[v].line;
            for (int k = 0; k < int'(FRAME); k++) begin
                want[int'(FRAME)-1-k] = ln[9 - k / int'(CLK_DIV)];
                cap[int'(FRAME)-1-k]  = bus.uart_tx;
                tick();
            end
            check("table_frame", 64'(cap), 64'(want));
            check("busy_after_frame", 64'(bus.tx_busy), 64'(0));
            check("tx_idle_after_frame", 64'(bus.uart_tx), 64'(1));
            repeat (3) tick();
        end
        check("table_rx_count", 64'(rx_q.size()), 64'(6));

        // Back-to-back burst.
        rx_q.delete();
        st_q.delete();
        strobe(8'h41);
        strobe(8'h42);
        strobe(8'h43);
        wait_idle(200);
        exp_q.delete();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        check_rx("burst");
        if (st_q.size() >= 3) begin
            check("burst_gap1", 64'(st_q[1] - st_q[0]), 64'(FRAME));
            check("burst_gap2", 64'(st_q[2] - st_q[1]), 64'(FRAME));
        end

        // Overflow: one popped, four queued, sixth dropped.
        rx_q.delete();
        for (int i = 0; i < 5; i++) strobe(8'(i));
        check("ovf_not_yet", 64'(bus.overflow), 64'(0));
        check("ovf_level_full", 64'(bus.fifo_level), 64'(4));
        strobe(8'h05);
        check("ovf_level_after_drop", 64'(bus.fifo_level), 64'(4));
        check("ovf_set", 64'(bus.overflow), 64'(1));
        wait_idle(400);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
        check_rx("ovf_rx");
        check("ovf_sticky", 64'(bus.overflow), 64'(1));
        check("ovf_drained", 64'(bus.fifo_level), 64'(0));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("ovf_cleared_by_reset", 64'(bus.overflow), 64'(0));

        // Push at full on the exact cycle the STOP bit ends and the next byte pops.
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h60 + 8'(i));
            strobe(8'h60 + 8'(i));
        end
        repeat (36) tick();
        check("full_before_stop_end", 64'(bus.fifo_level), 64'(4));
        strobe(8'h99);
        exp_q.push_back(8'h99);
        check("full_push_pop_level", 64'(bus.fifo_level), 64'(4));
        check("full_push_pop_no_ovf", 64'(bus.overflow), 64'(0));
        wait_idle(500);
        check_rx("full_push_pop_rx");

        // Reset in the middle of DATA bit 3 of 0xA5.
        rx_q.delete();
        strobe(8'hA5);
        strobe(8'h11);
        strobe(8'h22);
        repeat (17) tick();
        check("mid_bit3_low", 64'(bus.uart_tx), 64'(0));
        check("mid_level", 64'(bus.fifo_level), 64'(2));
        reset = 1'b1;
        #1;
        check("async_rst_tx", 64'(bus.uart_tx), 64'(1));
        check("async_rst_level", 64'(bus.fifo_level), 64'(0));
        check("async_rst_busy", 64'(bus.tx_busy), 64'(0));
        tick();
        reset = 1'b0;
        repeat (100) tick();
        check("no_frames_after_rst", 64'(rx_q.size()), 64'(0));
        check("idle_after_rst", 64'(bus.uart_tx), 64'(1));
        check("busy_after_rst", 64'(bus.tx_busy), 64'(0));

        // Randomized bursts of up to four bytes with optional gaps.
        rx_q.delete();
        exp_q.delete();
        for (int it = 0; it < 25; it++) begin
            len = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                strobe(b);
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 6)) tick();
            end
            wait_idle(300);
            repeat ($urandom_range(0, 5)) tick();
        end
        check_rx("rand_rx");
        check("rand_no_ovf", 64'(bus.overflow), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
